// File: rtl/ram_2x4_ctrl.sv
// Request/response controller for ram_2x4: serialises single read/write requests
// onto the RAM pins and returns read data over a valid/ready response channel.
module ram_2x4_ctrl #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned ADDR_W   = 1,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              wr_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept_c;
  logic             capture_c;

  // Next-state and latency counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        accept_c = req_valid & req_ready;
        if (accept_c) begin
          state_nxt = req_we ? WRITE : READ;
          cnt_nxt   = '0;
        end
      end
      WRITE: state_nxt = IDLE;
      READ: begin
        if (cnt == CNT_LAST) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
          capture_c = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      req_ready   <= 1'b0;
      wr_done     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      ram_rw      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      wr_done   <= (state_nxt == WRITE);
      ram_rw    <= (state_nxt == WRITE);
      rsp_valid <= (state_nxt == RESP);
      if (accept_c) ram_addr <= req_addr;
      if (accept_c && req_we) ram_data_in <= req_wdata;
      if (capture_c) rsp_rdata <= ram_data_out;
    end
  end

endmodule
